// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared sizing helper, mode constants and reset defaults for the sequence detector
package seqdet_pkg;

    function automatic int len_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

    localparam int   PAT_RST = 0;
    localparam int   LEN_RST = 0;
    localparam logic OVL_RST = OVL_ON;

endpackage

// File: rtl/pattern_seqdet_if.sv
// pattern_seqdet_if: configuration, serial input and match status bundle
interface pattern_seqdet_if #(parameter int PAT_W = 8, parameter int CNT_W = 16);

    localparam int LEN_W = seqdet_pkg::len_w(PAT_W);

    logic             cfg_we;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic             x_valid;
    logic             x;
    logic             cnt_clr;
    logic             z;
    logic [CNT_W-1:0] match_cnt;
    logic [LEN_W-1:0] fill;

    modport master (
        output cfg_we, cfg_pat, cfg_len, cfg_ovl, x_valid, x, cnt_clr,
        input  z, match_cnt, fill
    );

    modport slave (
        input  cfg_we, cfg_pat, cfg_len, cfg_ovl, x_valid, x, cnt_clr,
        output z, match_cnt, fill
    );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter whose clear wins over increment but still counts a coincident event
module sat_counter #(parameter int W = 16) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // clear loads the coincident increment; otherwise count up and stick at all-ones
    always_ff @(posedge clk)
        if (rst) q <= '0;
        else if (clr) q <= W'(inc);
        else if (inc && q != '1) q <= q + 1'b1;

endmodule

// File: rtl/pattern_seqdet.sv
// pattern_seqdet: run-time programmable serial pattern detector with registered match pulse
module pattern_seqdet
    import seqdet_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    pattern_seqdet_if.slave bus
);

    localparam int LEN_W = len_w(PAT_W);

    logic [PAT_W-1:0] pat, hist, hist_n, mask;
    logic [LEN_W-1:0] len, len_c, fill, fill_n;
    logic             ovl, acc, hit, z;

    assign acc    = bus.x_valid && !bus.cfg_we;
    assign len_c  = bus.cfg_len > LEN_W'(PAT_W) ? LEN_W'(PAT_W) : bus.cfg_len;
    assign mask   = ~({PAT_W{1'b1}} << len);
    assign hist_n = (hist << 1) | PAT_W'(bus.x);
    assign fill_n = fill == len ? len : fill + 1'b1;
    assign hit    = acc && len != '0 && fill_n == len && ((hist_n ^ pat) & mask) == '0;

    // config load clears history; a non-overlap match restarts the fill from empty
    always_ff @(posedge clk)
        if (rst) begin
            pat  <= PAT_W'(PAT_RST);
            len  <= LEN_W'(LEN_RST);
            ovl  <= OVL_RST;
            hist <= '0;
            fill <= '0;
            z    <= 1'b0;
        end else if (bus.cfg_we) begin
            pat  <= bus.cfg_pat;
            len  <= len_c;
            ovl  <= bus.cfg_ovl;
            hist <= '0;
            fill <= '0;
            z    <= 1'b0;
        end else begin
            z <= hit;
            if (acc) begin
                hist <= hit && ovl == OVL_OFF ? '0 : hist_n;
                fill <= hit && ovl == OVL_OFF ? '0 : fill_n;
            end
        end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(bus.cnt_clr),
        .inc(hit),
        .q(bus.match_cnt)
    );

    assign bus.z    = z;
    assign bus.fill = fill;

endmodule

// File: tb/tb_pattern_seqdet.sv
// tb_pattern_seqdet: scoreboard bench with a bit-queue reference model
module tb_pattern_seqdet;
    import seqdet_pkg::*;

    localparam int PW = 8, CW = 2, LW = len_w(PW);

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    pattern_seqdet_if #(.PAT_W(PW), .CNT_W(CW)) bus ();
    pattern_seqdet #(.PAT_W(PW), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic          z;
        logic [CW-1:0] cnt;
        logic [LW-1:0] fill;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_m, a_m;
    int tests = 0, fails = 0, z_seen = 0, z0 = 0;

    logic [PW-1:0] m_pat = '0;
    int   m_len = 0, m_cnt = 0;
    logic m_ovl = 1'b1;
    bit   hist_q[$];

    // one clock of stimulus; the model predicts what the outputs show after the next edge
    task automatic cycle(input logic r, we, v, xb, clr, input logic [PW-1:0] cp, input int cl, input logic co);
        bit   hit;
        int   f;
        exp_t e;
        @(negedge clk);
        rst = r; bus.cfg_we = we; bus.cfg_pat = cp; bus.cfg_len = LW'(cl);
        bus.cfg_ovl = co; bus.x_valid = v; bus.x = xb; bus.cnt_clr = clr;
        hit = 0;
        if (r) begin
            m_pat = '0; m_len = 0; m_ovl = 1'b1; m_cnt = 0; hist_q.delete();
        end else begin
            if (we) begin
                m_pat = cp; m_len = cl > PW ? PW : cl; m_ovl = co; hist_q.delete();
            end else if (v) begin
                hist_q.push_back(xb);
                if (hist_q.size() > PW) void'(hist_q.pop_front());
                if (m_len > 0 && hist_q.size() >= m_len) begin
                    hit = 1;
                    for (int i = 0; i < m_len; i++)
                        if (hist_q[hist_q.size() - m_len + i] != m_pat[m_len - 1 - i]) hit = 0;
                end
                if (hit && !m_ovl) hist_q.delete();
            end
            if (clr) m_cnt = hit ? 1 : 0;
            else if (hit && m_cnt < 2**CW - 1) m_cnt++;
        end
        f = hist_q.size() < m_len ? hist_q.size() : m_len;
        e = '{z: hit, cnt: CW'(m_cnt), fill: LW'(f)};
        exp_q.push_back(e);
    endtask

    task automatic idle();                  cycle(0, 0, 0, 0, 0, '0, 0, 1);  endtask
    task automatic clr_cnt();               cycle(0, 0, 0, 0, 1, '0, 0, 1);  endtask
    task automatic feed(input logic v, xb); cycle(0, 0, v, xb, 0, '0, 0, 1); endtask
    task automatic config_(input logic [PW-1:0] p, input int l, input logic o); cycle(0, 1, 0, 0, 0, p, l, o); endtask

    task automatic feed_bits(input logic [31:0] b, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            feed(1, b[i]);
            repeat (gap) feed(0, 1'($urandom));
        end
    endtask

    task automatic drain();
        idle();
        @(posedge clk); #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // compare every cycle's outputs against the oldest prediction
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_m = exp_q.pop_front();
            a_m = '{z: bus.z, cnt: bus.match_cnt, fill: bus.fill};
            tests++;
            if (a_m.z === 1'b1) z_seen++;
            if (a_m !== e_m) begin
                fails++;
                $display("FAIL outputs @%0t: got z=%0d cnt=%0d fill=%0d, expected z=%0d cnt=%0d fill=%0d",
                         $time, a_m.z, a_m.cnt, a_m.fill, e_m.z, e_m.cnt, e_m.fill);
            end
        end
    end

    initial begin
        cycle(1, 0, 0, 0, 0, '0, 0, 1);
        cycle(1, 0, 1, 1, 0, '0, 0, 1);
        idle();

        config_(8'b10010, 5, OVL_ON);
        z0 = z_seen; feed_bits(32'hC9094, 20, 0); drain();
        check("overlap_matches", z_seen - z0, 3);

        config_(8'b10010, 5, OVL_OFF); clr_cnt();
        z0 = z_seen; feed_bits(32'hC9094, 20, 0); drain();
        check("nonoverlap_matches", z_seen - z0, 2);

        config_(8'b10010, 5, OVL_ON); clr_cnt();
        z0 = z_seen; feed_bits(32'hC9094, 20, 3); drain();
        check("gapped_matches", z_seen - z0, 3);

        config_(8'h01, 1, OVL_OFF); clr_cnt();
        for (int i = 0; i < 16; i++) feed(1, 1'($urandom));
        clr_cnt();
        z0 = z_seen; feed_bits(32'h1F, 5, 0); drain();
        check("len1_five_ones", z_seen - z0, 5);
        cycle(0, 0, 1, 1, 1, '0, 0, 1);

        config_(8'hA5, 8, OVL_ON); clr_cnt();
        z0 = z_seen; feed_bits(32'hA5, 8, 0); drain();
        check("len8_match", z_seen - z0, 1);

        config_(8'h00, 0, OVL_ON);
        z0 = z_seen; feed_bits(32'h0, 16, 0); drain();
        check("len0_no_match", z_seen - z0, 0);

        config_(8'hA5, 9, OVL_ON);
        z0 = z_seen; feed_bits(32'h3A5, 10, 0); drain();
        check("len9_clamped", z_seen - z0, 1);

        config_(8'b10010, 5, OVL_ON);
        z0 = z_seen; feed_bits(32'b1001, 4, 0);
        config_(8'b10010, 5, OVL_ON);
        feed(1, 0); drain();
        check("cfg_mid_pattern", z_seen - z0, 0);

        feed_bits(32'b1001, 4, 0);
        cycle(0, 1, 1, 0, 0, 8'b10010, 5, 1);
        feed(1, 0);

        feed_bits(32'b1001, 4, 0);
        cycle(1, 0, 1, 0, 0, '0, 0, 1);
        z0 = z_seen; feed_bits(32'hC9094, 20, 0); drain();
        check("reset_disables", z_seen - z0, 0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0)
                cycle(1, 0, 1'($urandom), 1'($urandom), 0, '0, 0, 1);
            else if ($urandom_range(0, 39) == 0)
                cycle(0, 1, 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                      PW'($urandom), $urandom_range(0, 9), 1'($urandom));
            else
                cycle(0, 0, $urandom_range(0, 3) != 0, 1'($urandom),
                      $urandom_range(0, 29) == 0, '0, 0, 1);
        end
        idle();

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
